// File: rtl/test_vertex_pkg.sv
// Shared definitions for the test-geometry vertex source.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package test_vertex_pkg;

   // Vertex word geometry: 8 forced-zero bits, three X fields, three Y fields, then payload.
   localparam int WORD_W  = 224;
   localparam int FIELD_W = 12;
   localparam int TOP_LSB = 216;
   localparam int X_LSB   = 180;
   localparam int Y_LSB   = 144;
   localparam int PASS_W  = 144;

   localparam logic [1:0] MODE_PASS   = 2'd0;
   localparam logic [1:0] MODE_XSCALE = 2'd1;
   localparam logic [1:0] MODE_ROT    = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_LOAD,
      S_CALC,
      S_HOLD,
      S_DONE
   } state_t;

endpackage

// File: rtl/vertex_rot_unit.sv
// Transforms one coordinate about the screen centre (pass / X-scale / rotate), saturated.
// Latency: combinational result; mode/sin/cos are captured once per frame on cfg_ld.
// Backpressure: none; the caller sequences one coordinate per cycle.
module vertex_rot_unit import test_vertex_pkg::*; #(
   parameter int COORD_W = 12,
   parameter int TRIG_W  = 8,
   parameter int FRAC    = 7,
   parameter int CX      = 1280,
   parameter int CY      = 960
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cfg_ld,
   input  logic [1:0]                cfg_mode,
   input  logic signed [TRIG_W-1:0]  cfg_sin,
   input  logic signed [TRIG_W-1:0]  cfg_cos,
   input  logic signed [COORD_W:0]   dx,
   input  logic signed [COORD_W:0]   dy,
   input  logic                      sel_y,
   output logic [COORD_W-1:0]        res
);

   // Wide enough for a delta times a trig value plus the sum of two such products.
   localparam int PW = COORD_W + TRIG_W + 2;
   localparam logic signed [PW-1:0] CX_S  = PW'(CX);
   localparam logic signed [PW-1:0] CY_S  = PW'(CY);
   localparam logic signed [PW-1:0] MAX_S = PW'((1 << COORD_W) - 1);

   logic [1:0]               mode_q, mode_d;
   logic signed [TRIG_W-1:0] sin_q, sin_d, cos_q, cos_d;
   logic signed [PW-1:0]     dx_e, dy_e, ta_e, tb_e, m0, m1, delta, acc;
   logic signed [TRIG_W-1:0] trig_a, trig_b;

   // Per-frame transform settings, loaded only on the frame strobe
   always_comb begin
      mode_d = mode_q;
      sin_d  = sin_q;
      cos_d  = cos_q;
      if (cfg_ld) begin
         mode_d = cfg_mode;
         sin_d  = cfg_sin;
         cos_d  = cfg_cos;
      end
   end

   // Settings register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= '0;
         sin_q  <= '0;
         cos_q  <= '0;
      end else begin
         mode_q <= mode_d;
         sin_q  <= sin_d;
         cos_q  <= cos_d;
      end
   end

   // Two shared multipliers: m0 = dx*(sin|cos), m1 = dy*(cos|sin), then shift, recentre, saturate
   always_comb begin
      trig_a = (sel_y || (mode_q == MODE_XSCALE)) ? sin_q : cos_q;
      trig_b = sel_y ? cos_q : sin_q;
      dx_e   = {{(PW-COORD_W-1){dx[COORD_W]}}, dx};
      dy_e   = {{(PW-COORD_W-1){dy[COORD_W]}}, dy};
      ta_e   = {{(PW-TRIG_W){trig_a[TRIG_W-1]}}, trig_a};
      tb_e   = {{(PW-TRIG_W){trig_b[TRIG_W-1]}}, trig_b};
      m0     = dx_e * ta_e;
      m1     = dy_e * tb_e;
      case (mode_q)
         MODE_XSCALE: delta = sel_y ? dy_e : (m0 >>> FRAC);
         MODE_ROT:    delta = sel_y ? ((m0 + m1) >>> FRAC) : ((m0 - m1) >>> FRAC);
         default:     delta = sel_y ? dy_e : dx_e;
      endcase
      acc = delta + (sel_y ? CY_S : CX_S);
      if (acc[PW-1])
         res = '0;
      else if (acc > MAX_S)
         res = '1;
      else
         res = acc[COORD_W-1:0];
   end

endmodule

// File: rtl/test_vertex_rotator.sv
// Per-frame test-geometry source: walks the vertex ROM and rotates each entry's three vertices.
// Latency: 9 cycles from FETCH to a held word (fetch, ROM wait, load, 6 coordinate cycles).
// Backpressure: one word held until popped; nextFrame aborts and restarts at entry 0.
module test_vertex_rotator import test_vertex_pkg::*; #(
   parameter logic [7:0] SIZE    = 8'd108,
   parameter int         COORD_W = 12,
   parameter int         TRIG_W  = 8,
   parameter int         FRAC    = 7,
   parameter int         CX      = 1280,
   parameter int         CY      = 960
) (
   input  logic                     clk100,
   input  logic                     rst_n,
   input  logic                     nextFrame,
   input  logic [1:0]               mode,
   input  logic signed [TRIG_W-1:0] sin,
   input  logic signed [TRIG_W-1:0] cos,
   output logic [7:0]               rom_addr,
   input  logic [WORD_W-1:0]        rom_data,
   input  logic                     VertexBuffer_PreCalc_pop,
   output logic                     VertexBuffer_PreCalc_empty,
   output logic [WORD_W-1:0]        VertexBuffer_PreCalc_ReadData,
   output logic [7:0]               count
);

   localparam logic signed [COORD_W:0] CX_S = (COORD_W+1)'(CX);
   localparam logic signed [COORD_W:0] CY_S = (COORD_W+1)'(CY);

   state_t                  state_q, state_d;
   logic [7:0]              index_q, index_d, count_q, count_d;
   logic [2:0]              calc_q, calc_d;
   logic                    empty_q, empty_d;
   logic [WORD_W-1:0]       data_q, data_d;
   logic signed [COORD_W:0] dx_q [3];
   logic signed [COORD_W:0] dx_d [3];
   logic signed [COORD_W:0] dy_q [3];
   logic signed [COORD_W:0] dy_d [3];
   logic signed [COORD_W:0] op_dx, op_dy;
   logic [COORD_W-1:0]      res;
   logic [7:0]              field_lsb;
   logic                    last_entry;

   // The popped entry is the last one when the incremented index reaches SIZE
   assign last_entry = ({1'b0, index_q} + 9'd1) >= {1'b0, SIZE};

   // State register
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state: the frame strobe overrides everything, including a pop in HOLD
   always_comb begin
      state_d = state_q;
      if (nextFrame) begin
         state_d = S_FETCH;
      end else begin
         case (state_q)
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_LOAD;
            S_LOAD:  state_d = S_CALC;
            S_CALC:  state_d = (calc_q == 3'd5) ? S_HOLD : S_CALC;
            S_HOLD:  if (VertexBuffer_PreCalc_pop) state_d = last_entry ? S_DONE : S_FETCH;
            default: state_d = state_q;
         endcase
      end
   end

   // Outputs: empty is registered so it moves on the same edge that enters/leaves HOLD
   always_comb begin
      empty_d = (state_d != S_HOLD);
   end

   // Operand select for the current coordinate: calc 0..5 = x1,y1,x2,y2,x3,y3
   always_comb begin
      op_dx     = dx_q[0];
      op_dy     = dy_q[0];
      field_lsb = 8'(X_LSB + 2*COORD_W);
      case (calc_q)
         3'd0: begin op_dx = dx_q[0]; op_dy = dy_q[0]; field_lsb = 8'(X_LSB + 2*COORD_W); end
         3'd1: begin op_dx = dx_q[0]; op_dy = dy_q[0]; field_lsb = 8'(Y_LSB + 2*COORD_W); end
         3'd2: begin op_dx = dx_q[1]; op_dy = dy_q[1]; field_lsb = 8'(X_LSB + COORD_W);   end
         3'd3: begin op_dx = dx_q[1]; op_dy = dy_q[1]; field_lsb = 8'(Y_LSB + COORD_W);   end
         3'd4: begin op_dx = dx_q[2]; op_dy = dy_q[2]; field_lsb = 8'(X_LSB);             end
         3'd5: begin op_dx = dx_q[2]; op_dy = dy_q[2]; field_lsb = 8'(Y_LSB);             end
         default: ;
      endcase
   end

   vertex_rot_unit #(
      .COORD_W (COORD_W),
      .TRIG_W  (TRIG_W),
      .FRAC    (FRAC),
      .CX      (CX),
      .CY      (CY)
   ) u_rot (
      .clk      (clk100),
      .rst_n    (rst_n),
      .cfg_ld   (nextFrame),
      .cfg_mode (mode),
      .cfg_sin  (sin),
      .cfg_cos  (cos),
      .dx       (op_dx),
      .dy       (op_dy),
      .sel_y    (calc_q[0]),
      .res      (res)
   );

   // Datapath: frame counter, entry index, centred deltas and the output word
   always_comb begin
      index_d = index_q;
      count_d = count_q;
      calc_d  = calc_q;
      data_d  = data_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      if (nextFrame) begin
         count_d = count_q + 8'd1;
         index_d = '0;
      end else begin
         case (state_q)
            S_LOAD: begin
               data_d = rom_data;
               data_d[WORD_W-1:TOP_LSB] = '0;
               for (int k = 0; k < 3; k++) begin
                  dx_d[k] = $signed({1'b0, rom_data[X_LSB + (2-k)*COORD_W +: COORD_W]}) - CX_S;
                  dy_d[k] = $signed({1'b0, rom_data[Y_LSB + (2-k)*COORD_W +: COORD_W]}) - CY_S;
               end
               calc_d = '0;
            end
            S_CALC: begin
               data_d[field_lsb +: COORD_W] = res;
               calc_d = calc_q + 3'd1;
            end
            S_HOLD: if (VertexBuffer_PreCalc_pop) index_d = index_q + 8'd1;
            default: ;
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         index_q <= '0;
         count_q <= '0;
         calc_q  <= '0;
         empty_q <= 1'b1;
         data_q  <= '0;
         dx_q    <= '{default: '0};
         dy_q    <= '{default: '0};
      end else begin
         index_q <= index_d;
         count_q <= count_d;
         calc_q  <= calc_d;
         empty_q <= empty_d;
         data_q  <= data_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
      end
   end

   assign rom_addr                      = index_q;
   assign count                         = count_q;
   assign VertexBuffer_PreCalc_empty    = empty_q;
   assign VertexBuffer_PreCalc_ReadData = data_q;

endmodule

// File: tb/tb_test_vertex_rotator.sv
// Directed bench for test_vertex_rotator: two instances (default SIZE and SIZE=3) share the frame controls.
// Latency: each word expected exactly 9 cycles after the fetch that starts it.
// Backpressure: pops are issued one per held word; extra pops exercise the end-of-frame hold.
module tb_test_vertex_rotator;

   logic               clk100 = 1'b0;
   logic               rst_n, next_frame, pop, pop3, empty, empty3;
   logic [1:0]         mode;
   logic signed [7:0]  sin_v, cos_v;
   logic [7:0]         rom_addr, rom_addr3, count, count3;
   logic [223:0]       rom_data, rom_data3, rdata, rdata3;
   logic [223:0]       rom [256];
   int                 checks = 0;
   int                 errors = 0;
   int                 exp_count = 0;
   int                 lat;
   int                 spurious;

   always #5 clk100 = ~clk100;

   test_vertex_rotator dut (
      .clk100                        (clk100),
      .rst_n                         (rst_n),
      .nextFrame                     (next_frame),
      .mode                          (mode),
      .sin                           (sin_v),
      .cos                           (cos_v),
      .rom_addr                      (rom_addr),
      .rom_data                      (rom_data),
      .VertexBuffer_PreCalc_pop      (pop),
      .VertexBuffer_PreCalc_empty    (empty),
      .VertexBuffer_PreCalc_ReadData (rdata),
      .count                         (count)
   );

   test_vertex_rotator #(.SIZE(8'd3)) dut3 (
      .clk100                        (clk100),
      .rst_n                         (rst_n),
      .nextFrame                     (next_frame),
      .mode                          (mode),
      .sin                           (sin_v),
      .cos                           (cos_v),
      .rom_addr                      (rom_addr3),
      .rom_data                      (rom_data3),
      .VertexBuffer_PreCalc_pop      (pop3),
      .VertexBuffer_PreCalc_empty    (empty3),
      .VertexBuffer_PreCalc_ReadData (rdata3),
      .count                         (count3)
   );

   // Vertex ROM with one cycle read latency
   always @(posedge clk100) begin
      rom_data  <= rom[rom_addr];
      rom_data3 <= rom[rom_addr3];
   end

   function automatic logic [223:0] mk(input logic [11:0] x1, x2, x3, y1, y2, y3, input logic [7:0] tag);
      return {8'hAB, x1, x2, x3, y1, y2, y3, {18{tag}}};
   endfunction

   function automatic logic [223:0] strip(input logic [223:0] w);
      logic [223:0] r;
      r = w;
      r[223:216] = 8'h00;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [223:0] act, input logic [223:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic pulse();
      @(negedge clk100);
      next_frame = 1'b1;
      @(negedge clk100);
      next_frame = 1'b0;
      exp_count = (exp_count + 1) % 256;
   endtask

   task automatic wait_word(output int n);
      n = 0;
      while (empty !== 1'b0 && n < 40) begin
         @(negedge clk100);
         n++;
      end
   endtask

   task automatic wait_word3(output int n);
      n = 0;
      while (empty3 !== 1'b0 && n < 40) begin
         @(negedge clk100);
         n++;
      end
   endtask

   task automatic pop_main();
      pop = 1'b1;
      @(negedge clk100);
      pop = 1'b0;
   endtask

   task automatic pop_s3();
      pop3 = 1'b1;
      @(negedge clk100);
      pop3 = 1'b0;
   endtask

   task automatic start_frame(input logic [1:0] m, input int s, input int c);
      mode  = m;
      sin_v = 8'(s);
      cos_v = 8'(c);
      pulse();
      wait_word(lat);
      chk("latency", 224'(lat), 224'(9));
   endtask

   initial begin
      for (int i = 0; i < 256; i++)
         rom[i] = mk(12'd1536, 12'(1000 + i), 12'(2000 + i), 12'd960, 12'(900 + i), 12'(100 + i), 8'(i*7 + 3));
      rst_n = 1'b0; next_frame = 1'b0; mode = 2'd0; sin_v = '0; cos_v = '0; pop = 1'b0; pop3 = 1'b0;
      repeat (3) @(negedge clk100);
      chk("rst_empty", 224'(empty), 224'(1));
      chk("rst_data", rdata, 224'(0));
      chk("rst_addr", 224'(rom_addr), 224'(0));
      chk("rst_count", 224'(count), 224'(0));
      rst_n = 1'b1;
      @(negedge clk100);

      // Passthrough
      start_frame(2'd0, 0, 0);
      chk("m0_x1", 224'(rdata[215:204]), 224'(1536));
      chk("m0_y1", 224'(rdata[179:168]), 224'(960));
      chk("m0_top", 224'(rdata[223:216]), 224'(0));
      chk("m0_word", rdata, strip(rom[0]));
      chk("m0_count", 224'(count), 224'(exp_count));
      pop_main();
      chk("pop_empty", 224'(empty), 224'(1));

      // Rotation
      start_frame(2'd2, 0, 127);
      chk("rot_c_x1", 224'(rdata[215:204]), 224'(1534));
      chk("rot_c_y1", 224'(rdata[179:168]), 224'(960));
      start_frame(2'd2, 127, 0);
      chk("rot_s_x1", 224'(rdata[215:204]), 224'(1280));
      chk("rot_s_y1", 224'(rdata[179:168]), 224'(1214));

      // Legacy X-scale, including negative saturation
      rom[0] = mk(12'd1536, 12'd1000, 12'd2000, 12'd700, 12'd900, 12'd100, 8'd3);
      start_frame(2'd1, -128, 0);
      chk("xs_x1", 224'(rdata[215:204]), 224'(1024));
      chk("xs_y1", 224'(rdata[179:168]), 224'(700));
      chk("xs_x2", 224'(rdata[203:192]), 224'(1560));
      rom[0] = mk(12'd4095, 12'd1000, 12'd2000, 12'd700, 12'd900, 12'd100, 8'd3);
      start_frame(2'd1, -128, 0);
      chk("xs_sat_x1", 224'(rdata[215:204]), 224'(0));
      chk("xs_sat_y1", 224'(rdata[179:168]), 224'(700));

      // Mode 3 behaves as passthrough
      start_frame(2'd3, 127, 0);
      chk("m3_word", rdata, strip(rom[0]));
      rom[0] = mk(12'd1536, 12'd1000, 12'd2000, 12'd960, 12'd900, 12'd100, 8'd3);

      // SIZE=3 instance: exactly three words, then it stays empty
      start_frame(2'd0, 0, 0);
      for (int w = 0; w < 3; w++) begin
         wait_word3(lat);
         if (w > 0) chk("s3_lat", 224'(lat), 224'(9));
         chk("s3_addr", 224'(rom_addr3), 224'(w));
         chk("s3_word", rdata3, strip(rom[w]));
         pop_s3();
      end
      spurious = 0;
      repeat (20) begin
         @(negedge clk100);
         if (empty3 !== 1'b1) spurious++;
      end
      chk("s3_no_more", 224'(spurious), 224'(0));
      repeat (3) pop_s3();
      chk("s3_idx_cap", 224'(rom_addr3), 224'(3));
      chk("s3_empty", 224'(empty3), 224'(1));

      // Abort during CALC of entry 5
      start_frame(2'd0, 0, 0);
      for (int w = 0; w < 5; w++) begin
         if (w > 0) begin
            wait_word(lat);
            chk("ab_lat", 224'(lat), 224'(9));
         end
         chk("ab_addr", 224'(rom_addr), 224'(w));
         pop_main();
      end
      repeat (4) @(negedge clk100);
      chk("ab_mid_addr", 224'(rom_addr), 224'(5));
      chk("ab_mid_empty", 224'(empty), 224'(1));
      start_frame(2'd0, 0, 0);
      chk("ab_word", rdata, strip(rom[0]));
      chk("ab_count", 224'(count), 224'(exp_count));

      // nextFrame together with pop in HOLD: strobe wins
      pop = 1'b1;
      next_frame = 1'b1;
      @(negedge clk100);
      pop = 1'b0;
      next_frame = 1'b0;
      exp_count = (exp_count + 1) % 256;
      chk("sim_empty", 224'(empty), 224'(1));
      chk("sim_addr", 224'(rom_addr), 224'(0));
      chk("sim_count", 224'(count), 224'(exp_count));
      wait_word(lat);
      chk("sim_lat", 224'(lat), 224'(9));
      chk("sim_word", rdata, strip(rom[0]));

      // Asynchronous reset in the middle of CALC
      mode = 2'd0;
      pulse();
      repeat (5) @(negedge clk100);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_empty", 224'(empty), 224'(1));
      chk("ar_data", rdata, 224'(0));
      chk("ar_addr", 224'(rom_addr), 224'(0));
      chk("ar_count", 224'(count), 224'(0));
      exp_count = 0;
      @(negedge clk100);
      rst_n = 1'b1;
      spurious = 0;
      repeat (12) begin
         @(negedge clk100);
         if (empty !== 1'b1) spurious++;
      end
      chk("ar_quiet", 224'(spurious), 224'(0));
      start_frame(2'd0, 0, 0);
      chk("ar_count1", 224'(count), 224'(1));
      chk("ar_word", rdata, strip(rom[0]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
